// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame transmitter.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_LEN,
        S_PAY,
        S_CHK
    } state_t;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_t;

    localparam logic [7:0] SOF_BYTE  = 8'hA5;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Folds one byte into a CRC-8 (MSB-first, no reflection) in a single step.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with a combinational head and a live occupancy count.
// Latency: a pushed byte is visible at dout the cycle after the push.
// Backpressure: push is dropped when full, pop is ignored when empty.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Sends buffered payload as SOF, LEN, payload, CHK over the UART tx_start/tx_done handshake; UART_FRAME_CRC8_EN selects CRC-8 CHK.
// Latency: frame_go -> first tx_start next cycle; tx_done -> next tx_start next cycle unless payload is not yet buffered.
// Backpressure: in_ready follows !full; frame_go is ignored while busy; an empty FIFO stalls the payload field.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int         DEPTH = 16,
    parameter logic [7:0] SOF   = SOF_BYTE,
    parameter int         AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic [AW:0]   fifo_level,
    input  logic          frame_go,
    input  logic [7:0]    frame_len,
    output logic          busy,
    output logic          frame_done,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_done
);

    state_t     state;
    phase_t     phase;
    state_t     next_st;
    logic [7:0] len_r;
    logic [7:0] rem;
    logic [7:0] chk;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       adv;
    logic       pay_issue;

    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
`ifdef UART_FRAME_CRC8_EN
        return crc8_byte(acc, b);
`else
        return acc + b;
`endif
    endfunction

    assign in_ready = !fifo_full;

    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (pay_issue),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // rem already counts down at each payload issue, so zero means the payload is exhausted.
    always_comb begin
        next_st = S_IDLE;
        case (state)
            S_SOF:        next_st = S_LEN;
            S_LEN, S_PAY: next_st = (rem == 8'd0) ? S_CHK : S_PAY;
            default:      next_st = S_IDLE;
        endcase
        adv       = (state != S_IDLE) && (phase == PH_WAIT) && tx_done;
        pay_issue = !fifo_empty &&
                    (((state == S_PAY) && (phase == PH_ISSUE)) || (adv && (next_st == S_PAY)));
    end

    // Issuing happens on the edge that enters a field; the ISSUE phase only persists while payload stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            phase      <= PH_ISSUE;
            len_r      <= '0;
            rem        <= '0;
            chk        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            if (state == S_IDLE) begin
                if (frame_go) begin
                    len_r    <= frame_len;
                    rem      <= frame_len;
                    chk      <= '0;
                    busy     <= 1'b1;
                    state    <= S_SOF;
                    phase    <= PH_WAIT;
                    tx_start <= 1'b1;
                    tx_data  <= SOF;
                end
            end else if (pay_issue) begin
                state    <= S_PAY;
                phase    <= PH_WAIT;
                tx_start <= 1'b1;
                tx_data  <= fifo_dout;
                rem      <= rem - 8'd1;
                chk      <= chk_next(chk, fifo_dout);
            end else if (adv) begin
                case (next_st)
                    S_LEN: begin
                        state    <= S_LEN;
                        phase    <= PH_WAIT;
                        tx_start <= 1'b1;
                        tx_data  <= len_r;
                        chk      <= chk_next(chk, len_r);
                    end
                    S_PAY: begin
                        state <= S_PAY;
                        phase <= PH_ISSUE;
                    end
                    S_CHK: begin
                        state    <= S_CHK;
                        phase    <= PH_WAIT;
                        tx_start <= 1'b1;
                        tx_data  <= chk;
                    end
                    default: begin
                        state      <= S_IDLE;
                        phase      <= PH_ISSUE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Randomised bench for uart_frame_tx: a frame-index/queue reference model predicts every output each cycle.
// Honours UART_FRAME_CRC8_EN for the expected CHK byte.
module tb_uart_frame_tx;

    localparam int         DEPTH = 16;
    localparam int         AW    = $clog2(DEPTH);
    localparam logic [7:0] SOF_B = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [AW:0]   fifo_level;
    logic          frame_go;
    logic [7:0]    frame_len;
    logic          busy;
    logic          frame_done;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_done;

    always #5 clk = ~clk;

    uart_frame_tx #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fifo_level (fifo_level),
        .frame_go   (frame_go),
        .frame_len  (frame_len),
        .busy       (busy),
        .frame_done (frame_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] mq[$];
    logic [7:0] cap_q[$];
    bit         m_active = 0;
    bit         m_wait   = 0;
    int         m_idx    = 0;
    int         m_len    = 0;
    logic [7:0] m_chk    = 8'h00;
    logic [7:0] m_txd    = 8'h00;
    int         done_cnt = 0;
    int         done_dly = 20;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit-serial reference for the check byte.
    function automatic logic [7:0] ref_fold(input logic [7:0] acc, input logic [7:0] b);
`ifdef UART_FRAME_CRC8_EN
        logic [7:0] c;
        logic       fb;
        c = acc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
`else
        return 8'((int'(acc) + int'(b)) % 256);
`endif
    endfunction

    function automatic logic [7:0] frame_chk(input logic [7:0] q[$]);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 1; i < q.size(); i++) c = ref_fold(c, q[i]);
        return c;
    endfunction

    task automatic set_idle();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        frame_go = 1'b0;
        tx_done  = 1'b0;
    endtask

    task automatic auto_done(input int stray_pct);
        tx_done = 1'b0;
        if (m_wait) begin
            if (done_cnt == 0) tx_done = 1'b1;
            else done_cnt--;
        end else if (int'($urandom_range(99)) < stray_pct) begin
            tx_done = 1'b1;
        end
    endtask

    // One clock: advance the model from the driven inputs, then compare every output.
    task automatic step();
        int         pre_q;
        bit         can_issue;
        bit         is_pay;
        bit         exp_start;
        bit         exp_done;
        logic [7:0] b;
        pre_q     = mq.size();
        can_issue = 0;
        exp_start = 0;
        exp_done  = 0;
        if (rst) begin
            mq.delete();
            m_active = 0;
            m_wait   = 0;
            m_txd    = 8'h00;
            done_cnt = 0;
        end else begin
            if (!m_active) begin
                if (frame_go) begin
                    m_active  = 1;
                    m_len     = int'(frame_len);
                    m_idx     = 0;
                    m_chk     = 8'h00;
                    can_issue = 1;
                end
            end else if (m_wait) begin
                if (tx_done) begin
                    m_wait = 0;
                    if (m_idx == m_len + 3) begin
                        m_active = 0;
                        exp_done = 1;
                    end else begin
                        can_issue = 1;
                    end
                end
            end else begin
                can_issue = 1;
            end
            if (can_issue) begin
                is_pay = (m_idx >= 2) && (m_idx < m_len + 2);
                if (!is_pay || pre_q > 0) begin
                    if (m_idx == 0)      b = SOF_B;
                    else if (m_idx == 1) b = 8'(m_len);
                    else if (is_pay)     b = mq.pop_front();
                    else                 b = m_chk;
                    if (m_idx >= 1 && m_idx < m_len + 2) m_chk = ref_fold(m_chk, b);
                    m_idx++;
                    m_wait    = 1;
                    m_txd     = b;
                    exp_start = 1;
                    done_cnt  = done_dly;
                end
            end
            if (in_valid && pre_q < DEPTH) mq.push_back(in_data);
        end
        @(posedge clk);
        #1;
        if (tx_start) cap_q.push_back(tx_data);
        chk("tx_start", tx_start, exp_start);
        chk("tx_data", tx_data, m_txd);
        chk("busy", busy, m_active);
        chk("frame_done", frame_done, exp_done);
        chk("fifo_level", fifo_level, mq.size());
        chk("in_ready", in_ready, mq.size() < DEPTH);
    endtask

    task automatic cycles(input int n, input int push_pct, input int stray_pct);
        for (int i = 0; i < n; i++) begin
            set_idle();
            if (int'($urandom_range(99)) < push_pct) in_valid = 1'b1;
            auto_done(stray_pct);
            if (int'($urandom_range(99)) < stray_pct) begin
                frame_go  = 1'b1;
                frame_len = 8'($urandom);
            end
            step();
        end
    endtask

    task automatic start_frame(input int len);
        cap_q.delete();
        set_idle();
        frame_go  = 1'b1;
        frame_len = 8'(len);
        step();
    endtask

    task automatic finish_frame(input int push_pct, input int stray_pct, input int max_cyc);
        int n;
        n = 0;
        while (m_active && n < max_cyc) begin
            cycles(1, push_pct, stray_pct);
            n++;
        end
        chk("frame_end_busy", busy, 1'b0);
    endtask

    task automatic push_bytes(input logic [7:0] q[$]);
        foreach (q[i]) begin
            set_idle();
            in_valid = 1'b1;
            in_data  = q[i];
            auto_done(0);
            step();
        end
    endtask

    task automatic check_cap(input string tag, input logic [7:0] e[$]);
        chk({tag, "_count"}, cap_q.size(), e.size());
        for (int i = 0; i < e.size() && i < cap_q.size(); i++) chk(tag, cap_q[i], e[i]);
    endtask

    initial begin
        logic [7:0] e[$];
        int         n;

        set_idle();
        frame_len = 8'h00;
        rst = 1'b1;
        step();
        cycles(3, 0, 0);

        // Basic three-byte frame, slow UART.
        done_dly = 20;
        push_bytes('{8'h11, 8'h22, 8'h33});
        start_frame(3);
        finish_frame(0, 0, 400);
        e = '{SOF_B, 8'h03, 8'h11, 8'h22, 8'h33};
        e.push_back(frame_chk(e));
        check_cap("s1_byte", e);
`ifndef UART_FRAME_CRC8_EN
        chk("s1_sum_literal", cap_q[5], 8'h69);
`endif
        chk("s1_level", fifo_level, 0);

        // Zero-length frame.
        done_dly = 3;
        start_frame(0);
        finish_frame(0, 0, 100);
        check_cap("s2_byte", '{SOF_B, 8'h00, 8'h00});

        // Payload stall on an empty FIFO.
        start_frame(2);
        cycles(20, 0, 0);
        cycles(100, 0, 0);
        chk("s3_stall_count", cap_q.size(), 2);
        push_bytes('{8'h7F, 8'h80});
        finish_frame(0, 0, 100);
        e = '{SOF_B, 8'h02, 8'h7F, 8'h80};
        e.push_back(frame_chk(e));
        check_cap("s3_byte", e);

        // Overfill: the 17th byte must be dropped.
        e.delete();
        for (int i = 0; i < 17; i++) e.push_back(8'($urandom));
        push_bytes(e);
        chk("s4_full_level", fifo_level, 16);
        chk("s4_full_rdy", in_ready, 1'b0);
        start_frame(16);
        finish_frame(0, 0, 400);
        e = e[0:15];
        e.push_front(8'h10);
        e.push_front(SOF_B);
        e.push_back(frame_chk(e));
        check_cap("s4_byte", e);

        // Long frame with continuous refill, stray frame_go and tx_done.
        done_dly = 2;
        start_frame(255);
        finish_frame(60, 10, 5000);
        chk("s5_byte_count", cap_q.size(), 258);

        // Reset during a payload wait, then a clean frame.
        cycles(5, 0, 0);
        done_dly = 4;
        push_bytes('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        start_frame(5);
        n = 0;
        while (!(m_idx >= 3 && m_wait) && n < 200) begin
            cycles(1, 0, 0);
            n++;
        end
        chk("s6_reached_pay", m_idx >= 3, 1'b1);
        set_idle();
        rst = 1'b1;
        step();
        chk("s6_rst_busy", busy, 1'b0);
        chk("s6_rst_level", fifo_level, 0);
        set_idle();
        tx_done = 1'b1;
        step();
        cycles(3, 0, 0);
        push_bytes('{8'hC3, 8'h3C});
        start_frame(2);
        finish_frame(0, 0, 100);
        e = '{SOF_B, 8'h02, 8'hC3, 8'h3C};
        e.push_back(frame_chk(e));
        check_cap("s6_byte", e);

        // Random short frames.
        for (int k = 0; k < 6; k++) begin
            done_dly = int'($urandom_range(5, 1));
            start_frame(int'($urandom_range(20)));
            finish_frame(50, 15, 2000);
            cycles(int'($urandom_range(4)), 30, 15);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Client of the UART transmit handshake (tx_start / tx_data / tx_done) in the logic-analyser UART path. Buffers payload bytes in an internal FIFO. On command, emits one framed packet as a byte sequence to the UART transmitter: SOF, LEN, payload, CHK. The host side uses the frame to resynchronise and validate capture dumps.

Parameters:
DEPTH, 16, payload FIFO depth in bytes; power of 2, at least 2
SOF, 8'hA5, start-of-frame byte
AW, $clog2(DEPTH), FIFO address width (derived; do not override)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  payload byte offered
in_data  input  8  payload byte
in_ready  output  1  FIFO can accept a byte (equals !full)
fifo_level  output  AW+1  bytes currently held in FIFO
frame_go  input  1  one-cycle request to send a frame
frame_len  input  8  payload length, sampled with frame_go
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse when the frame completes
tx_start  output  1  one-cycle pulse to the UART transmitter
tx_data  output  8  byte to transmit; held stable until tx_done
tx_done  input  1  one-cycle pulse from the UART transmitter when the stop bit ends

Behaviour:
- Reset: tx_start=0, tx_data=0, busy=0, frame_done=0, fifo_level=0, in_ready=1 after the reset cycle. FIFO is flushed and the FSM returns to IDLE.
- FIFO push: occurs when in_valid && in_ready.
- FIFO pop: occurs only on a PAY issue cycle.
- Simultaneous push and pop when neither full nor empty: both take effect and the level is unchanged.
- When full, in_ready=0 and in_data is dropped with no side effect.
- Pointers wrap modulo DEPTH.
- FSM states: IDLE, SOF, LEN, PAY, CHK. Each non-IDLE state has two phases: ISSUE and WAIT.
- IDLE:
  - frame_go=1 latches frame_len into len_r and a remaining-byte counter.
  - The checksum register clears to 0.
  - busy rises next cycle; FSM moves to SOF/ISSUE.
- ISSUE phase:
  - In the same clock edge, tx_data is loaded and tx_start is driven 1 for exactly one cycle.
  - FSM then moves to WAIT.
- WAIT phase:
  - tx_start=0; FSM waits for tx_done.
  - On tx_done, it advances to the next field's ISSUE on the following cycle.
- Latency: frame_go in cycle N gives the first tx_start in cycle N+1. tx_done in cycle M gives the next tx_start in cycle M+1, unless PAY is stalled.
- Field sequence and data:
  - SOF sends SOF.
  - LEN sends len_r.
  - PAY sends the FIFO head (popped); repeats len_r times.
  - CHK sends the checksum.
- Length 0: LEN is followed directly by CHK.
- Checksum: modulo-256 sum of the LEN byte and all payload bytes. Overflow wraps silently.
- PAY stall: if the FIFO is empty at PAY/ISSUE, the FSM holds in PAY/ISSUE with tx_start=0. It issues in the first cycle after the FIFO becomes non-empty.
- End of frame:
  - tx_done in CHK/WAIT drives frame_done=1 and busy=0 in the next cycle; FSM returns to IDLE.
  - A new frame_go is accepted that same cycle.
- Ignored inputs:
  - frame_go is ignored while busy=1.
  - tx_done is ignored in IDLE and in any ISSUE phase.
- Reset mid-frame: the frame is aborted immediately and no frame_done is issued. A byte already in flight in the UART completes, and its tx_done is ignored.

Optional Feature:
UART_FRAME_CRC8_EN
- Defined: CHK is CRC-8 over LEN and the payload bytes, MSB-first, polynomial 0x07, init 0x00, no reflection, no final XOR. It is computed bytewise in one cycle at each load.
- Undefined: CHK is the modulo-256 sum. No CRC logic is synthesised.
- Ports and timing are identical in both builds.

Decomposition:
- Package uart_frame_pkg holds:
  - FSM state enum (IDLE, SOF, LEN, PAY, CHK) and the phase encoding
  - default SOF constant 8'hA5
  - CRC8 polynomial constant 8'h07
  - crc8_byte function
- One sub-module: uart_byte_fifo, a synchronous FIFO with parameter DEPTH and ports push, pop, din, dout (combinational head), full, empty, level.

Test Plan:
- Push 11,22,33; frame_go len=3; tx_done returned 20 cycles after each tx_start -> tx bytes A5,03,11,22,33,69. frame_done pulses once and fifo_level=0. The CRC8 build checks CHK against a bench CRC model.
- FIFO empty; frame_go len=0 -> bytes A5,00,00. Each tx_start lasts exactly 1 cycle; busy=0 the cycle after the last tx_done.
- FIFO empty; frame_go len=2 -> A5,02 sent, then no tx_start for 100 cycles. Push 7F, then 80 -> bytes 7F,80,01 follow.
- DEPTH=16; push 17 bytes back-to-back -> in_ready=0 after the 16th push and fifo_level=16. The 17th byte is absent from a subsequent len=16 frame.
- len=255 with the FIFO refilled continuously during the frame -> 258 bytes emitted with the wrapped sum correct. frame_go pulses and stray tx_done pulses injected during ISSUE are ignored.
- rst asserted during PAY/WAIT -> next cycle tx_start=0, busy=0, fifo_level=0, no frame_done. The late tx_done is ignored, and a new frame sends correctly.
